// File: rtl/axis_frame_demux_4_if.sv
// ---------------------------------------------------------------------------
// axis_frame_demux_4_if
//
// Purpose: one AXI-Stream link (data, valid, ready, last, user) shared by the
// frame demultiplexer's input side and each of its four output ports.
//
// Signals:
//   tdata  [DATA_WIDTH-1:0]  beat data
//   tvalid                   beat valid (source -> sink)
//   tready                   beat accepted when tvalid & tready (sink -> source)
//   tlast                    last beat of a frame
//   tuser  [USER_WIDTH-1:0]  sideband carried with the beat
//
// Modports:
//   master  drives tdata/tvalid/tlast/tuser, receives tready
//   slave   receives tdata/tvalid/tlast/tuser, drives tready
// ---------------------------------------------------------------------------
interface axis_frame_demux_4_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_demux_4.sv
// ---------------------------------------------------------------------------
// axis_frame_demux_4
//
// Purpose: frame-aware 1-to-4 AXI-Stream demultiplexer. A destination port
// (or a drop decision) is latched when a frame starts and every beat up to
// and including tlast is routed to that one port. Each output has a
// registered skid stage (output register + temp register), so src.tready is
// a register and no combinational ready path crosses the block.
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   rst      in   synchronous, active-high reset
//   src      in   AXI-Stream slave (input beats, tready driven here)
//   dst_0..3 out  AXI-Stream masters, one per output port
//   enable   in   permits a new frame to start; ignored mid-frame
//   drop     in   sampled at frame start: 1 = accept and discard the frame
//   select   in   destination port, sampled at frame start
//   busy     out  frame in progress
// ---------------------------------------------------------------------------
module axis_frame_demux_4 #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    axis_frame_demux_4_if.slave         src,
    axis_frame_demux_4_if.master        dst_0,
    axis_frame_demux_4_if.master        dst_1,
    axis_frame_demux_4_if.master        dst_2,
    axis_frame_demux_4_if.master        dst_3,
    input  logic                        enable,
    input  logic                        drop,
    input  logic [1:0]                  select,
    output logic                        busy
);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_ACTIVE = 1'b1;

    // Frame control state
    logic [0:0] frame_reg;
    logic [0:0] frame_next;
    logic [1:0] select_reg;
    logic [1:0] select_next;
    logic       drop_reg;
    logic       drop_next;
    logic       input_tready_reg;
    logic       input_tready_next;

    // Per-port skid handshake
    logic [3:0] out_tready;
    logic [3:0] input_valid_int;
    logic [3:0] ready_early;
    logic [3:0] ready_int_reg;

    // Input beat as seen by the skid stages
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [USER_WIDTH-1:0] in_user;
    logic                  accept;

    // Output register stage and temp (skid) register per port
    logic [DATA_WIDTH-1:0] out_data_p1 [4];
    logic [USER_WIDTH-1:0] out_user_p1 [4];
    logic [3:0]            out_last_p1;
    logic [3:0]            out_vld_p1;
    logic [DATA_WIDTH-1:0] tmp_data_p1 [4];
    logic [USER_WIDTH-1:0] tmp_user_p1 [4];
    logic [3:0]            tmp_last_p1;
    logic [3:0]            tmp_vld_p1;

    logic [3:0] out_vld_next;
    logic [3:0] tmp_vld_next;
    logic [3:0] store_in_to_out;
    logic [3:0] store_in_to_tmp;
    logic [3:0] store_tmp_to_out;

    assign in_data = src.tdata;
    assign in_last = src.tlast;
    assign in_user = (USER_ENABLE != 0) ? src.tuser : '0;

    assign out_tready = {dst_3.tready, dst_2.tready, dst_1.tready, dst_0.tready};

    // src.tready is only ever high while a frame is active, so a handshake
    // implies an active frame.
    assign accept = src.tvalid & input_tready_reg;

    // ---- input stage: routing decision and frame control ----
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            input_valid_int[n] = accept & !drop_reg & (select_reg == 2'(n));
            ready_early[n]     = out_tready[n]
                                 | (!tmp_vld_p1[n] & (!out_vld_p1[n] | !input_valid_int[n]));
        end
    end

    always_comb begin
        frame_next  = frame_reg;
        select_next = select_reg;
        drop_next   = drop_reg;

        case (frame_reg)
            STATE_IDLE: begin
                if (enable && src.tvalid) begin
                    frame_next  = STATE_ACTIVE;
                    select_next = select;
                    drop_next   = drop;
                end
            end
            STATE_ACTIVE: begin
                // Leaving through IDLE (never straight into a new frame)
                // guarantees at least one cycle between frames.
                if (accept && in_last) begin
                    frame_next = STATE_IDLE;
                end
            end
            default: begin
                frame_next = STATE_IDLE;
            end
        endcase

        // A drop frame never waits on an output port.
        input_tready_next = (frame_next == STATE_ACTIVE)
                            & (drop_next | ready_early[select_next]);
    end

    // ---- output stage: skid control per port ----
    // ready_int_reg[n] is the registered copy of ready_early[n]; for the
    // selected port it equals src.tready, so a beat only ever arrives at a
    // port whose stage promised room for it. The temp register is only
    // filled when ready is about to drop, so it is never valid while
    // ready_int_reg is high.
    always_comb begin
        out_vld_next     = out_vld_p1;
        tmp_vld_next     = tmp_vld_p1;
        store_in_to_out  = '0;
        store_in_to_tmp  = '0;
        store_tmp_to_out = '0;

        for (int n = 0; n < 4; n++) begin
            if (ready_int_reg[n]) begin
                if (out_tready[n] || !out_vld_p1[n]) begin
                    out_vld_next[n]    = input_valid_int[n];
                    store_in_to_out[n] = 1'b1;
                end else begin
                    tmp_vld_next[n]    = input_valid_int[n];
                    store_in_to_tmp[n] = 1'b1;
                end
            end else if (out_tready[n]) begin
                out_vld_next[n]     = tmp_vld_p1[n];
                tmp_vld_next[n]     = 1'b0;
                store_tmp_to_out[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg        <= STATE_IDLE;
            select_reg       <= 2'd0;
            drop_reg         <= 1'b0;
            input_tready_reg <= 1'b0;
            ready_int_reg    <= '0;
            out_vld_p1       <= '0;
            tmp_vld_p1       <= '0;
            out_last_p1      <= '0;
            tmp_last_p1      <= '0;
            for (int n = 0; n < 4; n++) begin
                out_data_p1[n] <= '0;
                out_user_p1[n] <= '0;
                tmp_data_p1[n] <= '0;
                tmp_user_p1[n] <= '0;
            end
        end else begin
            frame_reg        <= frame_next;
            select_reg       <= select_next;
            drop_reg         <= drop_next;
            input_tready_reg <= input_tready_next;
            ready_int_reg    <= ready_early;
            out_vld_p1       <= out_vld_next;
            tmp_vld_p1       <= tmp_vld_next;
            for (int n = 0; n < 4; n++) begin
                if (store_in_to_out[n] && input_valid_int[n]) begin
                    out_data_p1[n] <= in_data;
                    out_last_p1[n] <= in_last;
                    out_user_p1[n] <= in_user;
                end else if (store_tmp_to_out[n]) begin
                    out_data_p1[n] <= tmp_data_p1[n];
                    out_last_p1[n] <= tmp_last_p1[n];
                    out_user_p1[n] <= tmp_user_p1[n];
                end
                if (store_in_to_tmp[n] && input_valid_int[n]) begin
                    tmp_data_p1[n] <= in_data;
                    tmp_last_p1[n] <= in_last;
                    tmp_user_p1[n] <= in_user;
                end
            end
        end
    end

    assign src.tready = input_tready_reg;
    assign busy       = frame_reg[0];

    assign dst_0.tdata  = out_data_p1[0];
    assign dst_0.tvalid = out_vld_p1[0];
    assign dst_0.tlast  = out_last_p1[0];
    assign dst_0.tuser  = out_user_p1[0];

    assign dst_1.tdata  = out_data_p1[1];
    assign dst_1.tvalid = out_vld_p1[1];
    assign dst_1.tlast  = out_last_p1[1];
    assign dst_1.tuser  = out_user_p1[1];

    assign dst_2.tdata  = out_data_p1[2];
    assign dst_2.tvalid = out_vld_p1[2];
    assign dst_2.tlast  = out_last_p1[2];
    assign dst_2.tuser  = out_user_p1[2];

    assign dst_3.tdata  = out_data_p1[3];
    assign dst_3.tvalid = out_vld_p1[3];
    assign dst_3.tlast  = out_last_p1[3];
    assign dst_3.tuser  = out_user_p1[3];

endmodule

// File: doc/axis_frame_demux_4.md
# axis_frame_demux_4

Frame-aware 4-output AXI-Stream demultiplexer: the distribution end of the 4-input priority arbiter/mux path. It takes one AXI-Stream input, latches a destination (or drop) decision at the first beat of each frame, and routes every beat through tlast to exactly one of four outputs. Each output has a registered skid stage, so `input_tready` is a register and no combinational ready path crosses the block.

## Interface
- DATA_WIDTH, 8, tdata width in bits (≥1)
- USER_ENABLE, 1, 1 = carry tuser; 0 = outputs drive tuser = 0
- USER_WIDTH, 1, tuser width in bits

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_tdata  in  DATA_WIDTH  input beat data
- input_tvalid  in  1  input beat valid
- input_tready  out  1  input beat accepted when input_tvalid & input_tready
- input_tlast  in  1  last beat of frame
- input_tuser  in  USER_WIDTH  sideband, passed with beat
- output_N_tdata / _tvalid / _tlast / _tuser  out  as input  output port N, N = 0..3
- output_N_tready  in  1  downstream ready for port N
- enable  in  1  permits a new frame to start; ignored mid-frame
- drop  in  1  sampled at frame start: 1 = accept and discard the whole frame
- select  in  2  destination port, sampled at frame start
- busy  out  1  frame in progress (= frame_reg)

## Operation
- State: frame_reg (IDLE=0 / ACTIVE=1), select_reg[1:0], drop_reg.
- IDLE→ACTIVE: frame_reg=0 & enable & input_tvalid on edge → frame_reg=1, select_reg=select, drop_reg=drop. No beat is accepted on that cycle.
- ACTIVE→IDLE: on acceptance of a beat with input_tlast=1. If that cycle also meets the start condition (enable & input_tvalid after the handshake), the block does not chain frames. It returns to IDLE for at least one cycle.
- enable, select and drop changes while ACTIVE have no effect until the next frame start.
- Routing: an accepted beat goes only to port select_reg. Other ports' tvalid stays 0. If drop_reg=1, accepted beats go nowhere and all output tvalid stay 0.
- input_tready (registered) next = frame_next & (drop_next | ready_early[select_next]).
- Per-port skid stage: output register plus one temp register. ready_early[N] = output_N_tready | (!temp_valid[N] & (!output_valid[N] | !input_valid_int[N])), using standard Forencich skid semantics.
- No beat is lost, duplicated or reordered. A stalled output port never blocks a drop frame.
- tdata/tlast/tuser pass through unchanged. tuser forced to 0 when USER_ENABLE=0.

## Timing
- Reset (rst=1 on edge): input_tready=0, busy=0, all output_N_tvalid=0, temp valids=0, select_reg=0, drop_reg=0. Output tdata/tlast/tuser are don't-care but held at 0.
- Reset mid-frame: the partial frame is truncated and buffered beats are discarded. Remaining input beats after reset are treated as a new frame start (select re-sampled).
- Frame start at edge C → input_tready=1 at C+1 (if the port can accept) → first beat accepted at C+1 appears on output_N at C+2.
- Steady state: 1 beat/cycle throughput, 1-cycle latency input accept → output valid.
- Downstream stall: at most 2 beats buffered per port. input_tready falls within 1 cycle of output_N_tready=0 while output holds valid.
- Output handshake: output_N_tvalid, once high, stays high with stable data until output_N_tready=1.
- Minimum frame-to-frame gap on the input: 1 idle cycle after the tlast beat.

## Test plan
- Single frame: enable=1, select=2, drop=0, frame 0xA1,0xA2,0xA3(tlast), all readies=1 → output_2 emits A1..A3 on consecutive cycles starting 2 cycles after tvalid rises. Ports 0/1/3 tvalid stay 0. busy falls after the A3 accept.
- Select change mid-frame: start frame with select=1, switch select to 3 after the first beat → all 4 beats 0x10..0x13 appear on output_1 only. The next frame (select=3) goes to output_3.
- Backpressure: select=0, 8-beat frame 0x00..0x07, output_0_tready toggles 1,0,0,1,… → output_0 sequence exactly 0x00..0x07, no drops or duplicates. input_tready is low within 1 cycle of the stall. At most 2 beats accepted beyond the last output transfer.
- Drop: drop=1, select=0, output_0_tready=0, 5-beat frame → all 5 beats accepted at 1 beat/cycle, no output tvalid. A following frame with drop=0 is delivered normally.
- enable gating: enable=0 with input_tvalid=1 for 10 cycles → input_tready=0, busy=0. Raise enable → frame starts next edge.
- Reset mid-frame: assert rst for 1 cycle after the 2nd of 4 beats (select=1) → all tvalid=0, input_tready=0 next cycle. Remaining 2 beats form a new frame routed per the select present after reset.
